fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_stage_if.sv | 23 ++
 rtl/fetch_stage_if_id_reg.sv | 57 +++++
 rtl/fetch_stage.sv | 109 ++++++++++
 tb/tb_fetch_stage.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions for the fetch stage: FSM encoding, NOP word,
// PC increment and a PC alignment helper.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INCR   = 32'd4;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// IF/ID pipeline register bus: load/flush controls and next contents from
// the fetch control side, registered contents back from the register.
interface fetch_stage_if;
    logic        load;
    logic        flush;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic [31:0] instr_d;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4_q;
    logic [31:0] instr_q;
    logic        valid_q;

    modport master (
        output load, flush, pc_d, pc_plus4_d, instr_d,
        input  pc_q, pc_plus4_q, instr_q, valid_q
    );

    modport slave (
        input  load, flush, pc_d, pc_plus4_d, instr_d,
        output pc_q, pc_plus4_q, instr_q, valid_q
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. flush writes a bubble (valid cleared, bubble
// word), load captures a fetched instruction, otherwise contents hold.
// The PC fields are left untouched by a flush; they carry no meaning
// while valid is low.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
    input  logic               clk,
    input  logic               srst,
    fetch_stage_if.slave       bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    // Next register contents: flush wins over load, default is hold.
    always_comb begin
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        if (bus.flush) begin
            instr_d = BUBBLE_INSTR;
            valid_d = 1'b0;
        end else if (bus.load) begin
            pc_d       = bus.pc_d;
            pc_plus4_d = bus.pc_plus4_d;
            instr_d    = bus.instr_d;
            valid_d    = 1'b1;
        end
    end

    // Register update with synchronous reset to an empty bubble.
    always_ff @(posedge clk) begin
        if (srst) begin
            pc_q       <= 32'h0;
            pc_plus4_q <= 32'h0;
            instr_q    <= BUBBLE_INSTR;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.pc_q       = pc_q;
    assign bus.pc_plus4_q = pc_plus4_q;
    assign bus.instr_q    = instr_q;
    assign bus.valid_q    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection, INIT/RUN/HALTED
// control FSM and fetch counter. The IF/ID register lives in if_id_reg.
// InstrAddr comes straight from the PC flop, so InstrIn never feeds it.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        JumpTaken,
    input  logic [31:0] JumpTarget,
    input  logic        Halt,
    output logic [31:0] InstrAddr,
    input  logic [31:0] InstrIn,
    output logic [31:0] IfIdPC,
    output logic [31:0] IfIdPCPlus4,
    output logic [31:0] IfIdInstr,
    output logic        IfIdValid,
    output logic [31:0] FetchCount
);

    localparam logic [31:0] RESET_PC_ALIGNED = align_pc(RESET_PC);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_count_q, fetch_count_d;
    logic [31:0]  pc_plus4;

    fetch_stage_if ifid ();

    assign pc_plus4 = pc_q + PC_INCR;

    // Next state, next PC, counter and IF/ID controls.
    // Priority within RUN: Halt > Branch > Jump > Stall > advance.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        fetch_count_d   = fetch_count_q;
        ifid.load       = 1'b0;
        ifid.flush      = 1'b0;
        ifid.pc_d       = pc_q;
        ifid.pc_plus4_d = pc_plus4;
        ifid.instr_d    = InstrIn;
        case (state_q)
            ST_INIT: begin
                pc_d       = RESET_PC_ALIGNED;
                ifid.flush = 1'b1;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (Halt) begin
                    ifid.flush = 1'b1;
                    state_d    = ST_HALTED;
                end else if (BranchTaken) begin
                    pc_d       = align_pc(BranchTarget);
                    ifid.flush = 1'b1;
                end else if (JumpTaken) begin
                    pc_d       = align_pc(JumpTarget);
                    ifid.flush = 1'b1;
                end else if (!Stall) begin
                    pc_d          = pc_plus4;
                    ifid.load     = 1'b1;
                    fetch_count_d = fetch_count_q + 32'd1;
                end
            end
            ST_HALTED: begin
                ifid.flush = 1'b1;
            end
            default: begin
                ifid.flush = 1'b1;
                state_d    = ST_HALTED;
            end
        endcase
    end

    // State, PC and counter registers; Reset overrides everything.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_INIT;
            pc_q          <= RESET_PC_ALIGNED;
            fetch_count_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    if_id_reg #(
        .BUBBLE_INSTR (BUBBLE_INSTR)
    ) u_if_id_reg (
        .clk  (Clk),
        .srst (Reset),
        .bus  (ifid.slave)
    );

    assign InstrAddr   = pc_q;
    assign IfIdPC      = ifid.pc_q;
    assign IfIdPCPlus4 = ifid.pc_plus4_q;
    assign IfIdInstr   = ifid.instr_q;
    assign IfIdValid   = ifid.valid_q;
    assign FetchCount  = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: table of per-cycle vectors with
// expected post-edge outputs queued on a scoreboard, plus a short
// hand-written sequence for redirect/stall/halt interplay.
module tb_fetch_stage;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0100;
    localparam logic [31:0] TB_BUBBLE   = 32'h0000_0013;

    logic        Clk = 1'b0;
    logic        Reset, Stall, BranchTaken, JumpTaken, Halt;
    logic [31:0] BranchTarget, JumpTarget;
    logic [31:0] InstrAddr, InstrIn, FetchCount;

    fetch_stage_if mon ();

    assign mon.load       = 1'b0;
    assign mon.flush      = 1'b0;
    assign mon.pc_d       = 32'h0;
    assign mon.pc_plus4_d = 32'h0;
    assign mon.instr_d    = 32'h0;

    // Instruction memory model: distinctive word per address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign InstrIn = imem(InstrAddr);

    always #5 Clk = ~Clk;

    fetch_stage #(
        .RESET_PC     (TB_RESET_PC),
        .BUBBLE_INSTR (TB_BUBBLE)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .JumpTaken    (JumpTaken),
        .JumpTarget   (JumpTarget),
        .Halt         (Halt),
        .InstrAddr    (InstrAddr),
        .InstrIn      (InstrIn),
        .IfIdPC       (mon.pc_q),
        .IfIdPCPlus4  (mon.pc_plus4_q),
        .IfIdInstr    (mon.instr_q),
        .IfIdValid    (mon.valid_q),
        .FetchCount   (FetchCount)
    );

    typedef struct {
        logic        rst, stall, br;
        logic [31:0] btgt;
        logic        jmp;
        logic [31:0] jtgt;
        logic        halt;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        chk_if;
        logic [31:0] e_ifpc, e_ifpc4, e_cnt;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        chk_if;
        logic [31:0] e_ifpc, e_ifpc4, e_instr, e_cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(
        input logic rst, input logic stall, input logic br, input logic [31:0] btgt,
        input logic jmp, input logic [31:0] jtgt, input logic halt,
        input logic [31:0] e_pc, input logic e_valid, input logic chk_if,
        input logic [31:0] e_ifpc, input logic [31:0] e_ifpc4, input logic [31:0] e_cnt);
        vec_t v;
        v.rst = rst; v.stall = stall; v.br = br; v.btgt = btgt;
        v.jmp = jmp; v.jtgt = jtgt; v.halt = halt;
        v.e_pc = e_pc; v.e_valid = e_valid; v.chk_if = chk_if;
        v.e_ifpc = e_ifpc; v.e_ifpc4 = e_ifpc4; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL txn %0d %s: got %h expected %h", id, name, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare against the DUT outputs.
    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        $display("txn %0d: pc=%h valid=%b ifpc=%h ifpc4=%h instr=%h cnt=%0d",
                 e.id, InstrAddr, mon.valid_q, mon.pc_q, mon.pc_plus4_q, mon.instr_q, FetchCount);
        chk(e.id, "pc", InstrAddr, e.e_pc);
        chk(e.id, "valid", {31'h0, mon.valid_q}, {31'h0, e.e_valid});
        chk(e.id, "instr", mon.instr_q, e.e_instr);
        chk(e.id, "count", FetchCount, e.e_cnt);
        if (e.chk_if) begin
            chk(e.id, "ifpc", mon.pc_q, e.e_ifpc);
            chk(e.id, "ifpc4", mon.pc_plus4_q, e.e_ifpc4);
        end
    endtask

    task automatic apply(input vec_t t, input int id);
        exp_t e;
        Reset        = t.rst;
        Stall        = t.stall;
        BranchTaken  = t.br;
        BranchTarget = t.btgt;
        JumpTaken    = t.jmp;
        JumpTarget   = t.jtgt;
        Halt         = t.halt;
        e.id      = id;
        e.e_pc    = t.e_pc;
        e.e_valid = t.e_valid;
        e.chk_if  = t.chk_if;
        e.e_ifpc  = t.e_ifpc;
        e.e_ifpc4 = t.e_ifpc4;
        e.e_instr = t.e_valid ? imem(t.e_ifpc) : TB_BUBBLE;
        e.e_cnt   = t.e_cnt;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        compare_out();
    endtask

    initial begin
        Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; JumpTaken = 1'b0; Halt = 1'b0;
        BranchTarget = 32'h0; JumpTarget = 32'h0;

        //            rst st br btgt          jmp jtgt          hlt  e_pc          v  chk ifpc          ifpc4         cnt
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,         0, 32'h100,      0, 1, 32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h100,      0, 0, 32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h104,      1, 1, 32'h100,      32'h104,      1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h108,      1, 1, 32'h104,      32'h108,      2));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h4,         0, 32'h4,        0, 0, 32'h0,        32'h0,        2));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h8,        1, 1, 32'h4,        32'h8,        3));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,         0, 32'h8,        1, 1, 32'h4,        32'h8,        3));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,         0, 32'h8,        1, 1, 32'h4,        32'h8,        3));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,         0, 32'h8,        1, 1, 32'h4,        32'h8,        3));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         0, 32'hC,        1, 1, 32'h8,        32'hC,        4));
        tbl.push_back(mk(0, 1, 1, 32'h40,       1, 32'h80,        0, 32'h40,       0, 0, 32'h0,        32'h0,        4));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h44,       1, 1, 32'h40,       32'h44,       5));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h203,       0, 32'h200,      0, 0, 32'h0,        32'h0,        5));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h204,      1, 1, 32'h200,      32'h204,      6));
        tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC,0, 0, 32'h0,        32'h0,        6));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h0,        1, 1, 32'hFFFF_FFFC,32'h0,        7));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h4,        1, 1, 32'h0,        32'h4,        8));
        tbl.push_back(mk(0, 0, 1, 32'h1C,       0, 32'h0,         0, 32'h1C,       0, 0, 32'h0,        32'h0,        8));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h20,       1, 1, 32'h1C,       32'h20,       9));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h20,       0, 0, 32'h0,        32'h0,        9));
        tbl.push_back(mk(0, 0, 1, 32'h40,       0, 32'h0,         0, 32'h20,       0, 0, 32'h0,        32'h0,        9));
        tbl.push_back(mk(0, 1, 0, 32'h0,        1, 32'h80,        0, 32'h20,       0, 0, 32'h0,        32'h0,        9));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h20,       0, 0, 32'h0,        32'h0,        9));
        tbl.push_back(mk(1, 0, 1, 32'h40,       0, 32'h0,         1, 32'h100,      0, 1, 32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h100,      0, 0, 32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h104,      1, 1, 32'h100,      32'h104,      1));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,         0, 32'h104,      1, 1, 32'h100,      32'h104,      1));
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,         0, 32'h100,      0, 1, 32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,         0, 32'h100,      0, 0, 32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h104,      1, 1, 32'h100,      32'h104,      1));

        #2;
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Hand sequence: branch while stalled flushes a valid IF/ID, the
        // bubble is then held by a stall, and Halt with Stall still halts.
        apply(mk(0, 1, 1, 32'h12,  0, 32'h0, 0, 32'h10, 0, 0, 32'h0,  32'h0,  1), 100);
        apply(mk(0, 1, 0, 32'h0,   0, 32'h0, 0, 32'h10, 0, 0, 32'h0,  32'h0,  1), 101);
        apply(mk(0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h14, 1, 1, 32'h10, 32'h14, 2), 102);
        apply(mk(0, 1, 0, 32'h0,   0, 32'h0, 1, 32'h14, 0, 0, 32'h0,  32'h0,  2), 103);
        apply(mk(0, 0, 0, 32'h0,   1, 32'h8, 0, 32'h14, 0, 0, 32'h0,  32'h0,  2), 104);
        apply(mk(0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h14, 0, 0, 32'h0,  32'h0,  2), 105);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d entries expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
